// File: rtl/uart_tx_pkg.sv
// Shared UART constants and FSM encoding, common to the transmitter and the future receiver.
package uart_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int DEF_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud
   localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] clk_cnt;

   always_ff @(posedge clk) begin
      if (reset || clear || tick) clk_cnt <= '0;
      else                        clk_cnt <= clk_cnt + CW'(1);
   end

   assign tick = (clk_cnt == TERM);

endmodule

// File: rtl/uart_tx.sv
// 8N1-style serial transmitter: start bit, DATA_BITS data bits LSB first, stop bit; line idles high.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int BW = $clog2(DATA_BITS) + 1;
   localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

   state_t               state, state_n;
   logic [DATA_BITS-1:0] shift_reg, shift_n;
   logic [BW-1:0]        bit_cnt, bit_n;
   logic                 tx_n, busy_n, done_n;
   logic                 tick, last_bit;

   // Counter is held at zero while idle so the accept edge starts a fresh bit period.
   uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (state == IDLE),
      .tick  (tick)
   );

   assign last_bit = (bit_cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         tx        <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else begin
         state     <= state_n;
         tx        <= tx_n;
         tx_busy   <= busy_n;
         tx_done   <= done_n;
         shift_reg <= shift_n;
         bit_cnt   <= bit_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (tx_start)         state_n = START;
         START:   if (tick)             state_n = DATA;
         DATA:    if (tick && last_bit) state_n = STOP;
         STOP:    if (tick)             state_n = IDLE;
         default:                       state_n = IDLE;
      endcase
   end

   // Next values of the registered outputs and datapath; tx only ever changes on a clock edge.
   always_comb begin
      tx_n    = tx;
      busy_n  = tx_busy;
      done_n  = 1'b0;
      shift_n = shift_reg;
      bit_n   = bit_cnt;
      case (state)
         IDLE: if (tx_start) begin
            shift_n = tx_data;
            tx_n    = 1'b0;
            busy_n  = 1'b1;
            bit_n   = '0;
         end
         START: if (tick) begin
            tx_n    = shift_reg[0];
            shift_n = shift_reg >> 1;
            bit_n   = '0;
         end
         DATA: if (tick) begin
            if (last_bit) begin
               tx_n = 1'b1;
            end else begin
               tx_n    = shift_reg[0];
               shift_n = shift_reg >> 1;
               bit_n   = bit_cnt + BW'(1);
            end
         end
         STOP: if (tick) begin
            tx_n   = 1'b1;
            busy_n = 1'b0;
            done_n = 1'b1;
         end
         default: begin
            tx_n   = 1'b1;
            busy_n = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-scenario tasks plus a mid-bit sampling receiver checked against a byte scoreboard.
module tb_uart_tx;

   localparam int CPB = 4;
   localparam int DB  = 8;
   localparam int FRAME = (DB + 2) * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx, tx_busy, tx_done;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx       (tx),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   always #5 clk = ~clk;

   // Receiver model: frame cycle 0 is the first falling edge with tx low; each bit sampled at cycle 2 of 4.
   bit         rx_act = 1'b0;
   bit         rx_err = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_byte = 8'h00;
   logic [7:0] rx_exp;

   always @(negedge clk) begin
      if (reset) begin
         rx_act = 1'b0;
      end else if (!rx_act) begin
         if (tx === 1'b0) begin
            rx_act = 1'b1;
            rx_cnt = 0;
            rx_err = 1'b0;
         end
      end else begin
         rx_cnt++;
      end
      if (rx_act && !reset) begin
         if (rx_cnt % CPB == 2) begin
            if (rx_cnt / CPB == 0) begin
               if (tx !== 1'b0) rx_err = 1'b1;
            end else if (rx_cnt / CPB <= DB) begin
               rx_byte[rx_cnt / CPB - 1] = tx;
            end else if (tx !== 1'b1) begin
               rx_err = 1'b1;
            end
         end
         if (rx_cnt < FRAME && (tx_busy !== 1'b1 || tx_done !== 1'b0)) rx_err = 1'b1;
         if (rx_cnt == FRAME) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL rx_frame: unexpected frame got %02h, none required", rx_byte);
            end else begin
               rx_exp = exp_q.pop_front();
               if (rx_byte !== rx_exp || rx_err || tx_done !== 1'b1) begin
                  n_err++;
                  $display("FAIL rx_frame: got %02h err=%0b done=%b, required %02h err=0 done=1",
                           rx_byte, rx_err, tx_done, rx_exp);
               end
            end
            rx_act = 1'b0;
         end
      end
   end

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      tx_data  = b;
      tx_start = 1'b1;
      exp_q.push_back(b);
      @(posedge clk); #1;
      tx_start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4 * FRAME; i++) begin
         @(negedge clk);
         if (tx_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      bit bad;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_vals: tx=%b busy=%b done=%b, required 1 0 0", tx, tx_busy, tx_done);
      end
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad = 1'b1;
      end
      n_vec++;
      if (bad) begin
         n_err++;
         $display("FAIL idle_hold: outputs moved with tx_start=0, required tx=1 busy=0 done=0");
      end
   endtask

   task automatic test_frame_a5;
      logic [9:0] pat;
      pat = {1'b1, 8'hA5, 1'b0};
      send(8'hA5);
      for (int k = 0; k < FRAME; k++) begin
         @(negedge clk);
         n_vec++;
         if (tx !== pat[k / CPB] || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
            n_err++;
            $display("FAIL a5_bits cyc %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                     k, tx, tx_busy, tx_done, pat[k / CPB]);
         end
      end
      @(negedge clk);
      n_vec++;
      if (tx_done !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1) begin
         n_err++;
         $display("FAIL a5_done at cyc 40: tx=%b busy=%b done=%b, required 1 0 1", tx, tx_busy, tx_done);
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      @(posedge clk); #1;
      tx_data  = 8'h00;
      tx_start = 1'b1;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      @(posedge clk); #1;
      tx_data = 8'hFF;
      wait_done(ok);
      n_vec++;
      if (!ok || tx !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_first_done: done_seen=%0b tx=%b, required 1 1", ok, tx);
      end
      @(negedge clk);
      n_vec++;
      if (tx !== 1'b0 || tx_busy !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_gap: tx=%b busy=%b after done, required 0 1", tx, tx_busy);
      end
      tx_start = 1'b0;
      wait_done(ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL b2b_second_done: timeout, required tx_done pulse");
      end
   endtask

   task automatic test_busy_ignore;
      bit ok, bad;
      send(8'hA5);
      repeat (9) @(posedge clk);
      #1;
      tx_data  = 8'h3C;
      tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
      wait_done(ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL busy_ignore_done: timeout, required tx_done pulse");
      end
      bad = 1'b0;
      repeat (2 * FRAME) begin
         @(negedge clk);
         if (tx_busy !== 1'b0 || tx !== 1'b1) bad = 1'b1;
      end
      n_vec++;
      if (bad) begin
         n_err++;
         $display("FAIL busy_ignore_extra: second frame started, required none");
      end
   endtask

   task automatic test_reset_mid;
      bit ok, bad;
      send(8'h96);
      repeat (16) @(posedge clk);
      #1;
      void'(exp_q.pop_back());
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (tx !== 1'b1 || tx_busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid: tx=%b busy=%b, required 1 0", tx, tx_busy);
      end
      reset = 1'b0;
      bad = 1'b0;
      repeat (2 * FRAME) begin
         @(negedge clk);
         if (tx_done !== 1'b0) bad = 1'b1;
      end
      n_vec++;
      if (bad) begin
         n_err++;
         $display("FAIL reset_mid_done: tx_done pulsed after abort, required no pulse");
      end
      send(8'h5A);
      wait_done(ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL reset_mid_resend: timeout, required tx_done pulse");
      end
   endtask

   task automatic test_random;
      bit ok;
      int tmo;
      tmo = 0;
      for (int i = 0; i < 256; i++) begin
         send(8'($urandom_range(0, 255)));
         wait_done(ok);
         if (!ok) tmo++;
      end
      n_vec++;
      if (tmo != 0) begin
         n_err++;
         $display("FAIL random_done: %0d timeouts, required 0", tmo);
      end
   endtask

   initial begin
      test_reset;
      test_frame_a5;
      test_back_to_back;
      test_busy_ignore;
      test_reset_mid;
      test_random;
      repeat (5) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d frames outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
